// File: rtl/regfile_dump_defs.sv
// rtl/regfile_dump_defs.sv - shared state encodings and index width for the register dump reader
package regfile_dump_defs;

  localparam int IDX_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t READ = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - (index, data) dump stream between the reader and its debug sink
interface regfile_dump_reader_if #(
  parameter int N = 32
);
  import regfile_dump_defs::*;

  logic             dump_valid;
  logic             dump_ready;
  logic [IDX_W-1:0] dump_index;
  logic [N-1:0]     dump_data;

  modport master (
    output dump_valid,
    output dump_index,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_index,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks register indices through one read port and streams each value out
// FSM plus index counter plus capture registers; ReadRegister and busy decode straight from flops.
module regfile_dump_reader
  import regfile_dump_defs::*;
#(
  parameter int N        = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_W-1:0]      ReadRegister,
  input  logic [N-1:0]          ReadData,
  regfile_dump_reader_if.master dump,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] counter;
  logic             handshake;
  logic             last;

  assign handshake = dump.dump_valid & dump.dump_ready;
  assign last      = (counter == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort wins over everything except that a same-cycle handshake still counts as delivered
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = READ;
      READ: state_nxt = abort ? IDLE : HOLD;
      HOLD: begin
        if (abort)          state_nxt = IDLE;
        else if (handshake) state_nxt = last ? DONE : READ;
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    ReadRegister = counter;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter         <= '0;
      dump.dump_valid <= 1'b0;
      dump.dump_index <= '0;
      dump.dump_data  <= '0;
      done            <= 1'b0;
    end else begin
      dump.dump_valid <= (state_nxt == HOLD);
      done            <= (state_nxt == DONE);
      if (state == IDLE && start && !abort) begin
        counter <= '0;
      end else if (state == HOLD && handshake && !last && !abort) begin
        counter <= counter + 1'b1;
      end
      if (state == READ && !abort) begin
        dump.dump_index <= counter;
        dump.dump_data  <= ReadData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - scoreboard bench for the register dump reader
module tb_regfile_dump_reader;
  import regfile_dump_defs::*;

  localparam int N        = 32;
  localparam int NUM_REGS = 32;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [IDX_W-1:0] ReadRegister;
  logic [N-1:0]     ReadData;
  logic             busy;
  logic             done;
  logic [N-1:0]     regs [32];

  regfile_dump_reader_if #(.N(N)) dump ();

  regfile_dump_reader #(.N(N), .NUM_REGS(NUM_REGS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .ReadRegister (ReadRegister),
    .ReadData     (ReadData),
    .dump         (dump),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign ReadData = (ReadRegister == 5'd0) ? '0 : regs[ReadRegister];

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     data;
  } word_t;

  word_t exp_q[$];
  int    passed   = 0;
  int    total    = 0;
  int    pos      = 0;
  int    done_cnt = 0;
  int    done_pos = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  always @(posedge clk) pos++;

  // Monitor: pops on each handshake and checks that a stalled word is held steady
  logic             prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx   = '0;
  logic [N-1:0]     prev_data  = '0;
  always @(negedge clk) begin
    word_t w;
    if (done) begin
      done_cnt++;
      done_pos = pos;
    end
    if (prev_stall) begin
      check("stall_valid", dump.dump_valid, 1'b1);
      check("stall_index", dump.dump_index, prev_idx);
      check("stall_data", dump.dump_data, prev_data);
    end
    if (dump.dump_valid && dump.dump_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", dump.dump_index, 64'hFFFF);
      end else begin
        w = exp_q.pop_front();
        check("word_index", dump.dump_index, w.idx);
        check("word_data", dump.dump_data, w.data);
      end
    end
    prev_stall = dump.dump_valid && !dump.dump_ready && !abort && reset;
    prev_idx   = dump.dump_index;
    prev_data  = dump.dump_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi, input bit wr7);
    word_t w;
    for (int i = lo; i <= hi; i++) begin
      w.idx  = IDX_W'(i);
      w.data = (i == 0) ? 32'h0 : (i == 7 && wr7) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ReadRegister"}, ReadRegister, 5'd0);
    check({tag, "_valid"}, dump.dump_valid, 1'b0);
    check({tag, "_index"}, dump.dump_index, 5'd0);
    check({tag, "_data"}, dump.dump_data, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Drives one dump from start until busy drops; -1 disables each event
  task automatic run_dump(input int stall_idx, input int abort_idx, input int restart_idx,
                          input int wr_idx, output int start_pos_o, output int stalls_o);
    bit ended   = 0;
    bit rstrt   = 0;
    bit written = 0;
    stalls_o    = 0;
    start       = 1'b1;
    start_pos_o = pos;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400 && !ended; c++) begin
      dump.dump_ready = 1'b1;
      abort           = 1'b0;
      start           = 1'b0;
      if (dump.dump_valid) begin
        if (int'(dump.dump_index) == stall_idx && stalls_o < 5) begin
          dump.dump_ready = 1'b0;
          stalls_o++;
        end
        if (int'(dump.dump_index) == abort_idx) begin
          dump.dump_ready = 1'b0;
          abort           = 1'b1;
        end
        if (int'(dump.dump_index) == restart_idx && !rstrt) begin
          start = 1'b1;
          rstrt = 1;
        end
        if (int'(dump.dump_index) == wr_idx && !written) begin
          regs[7] = 32'hDEAD_BEEF;
          written = 1;
        end
      end
      tick();
      if (!busy) ended = 1;
    end
    if (!ended) check("run_timeout", 1'b0, 1'b1);
    abort           = 1'b0;
    start           = 1'b0;
    dump.dump_ready = 1'b1;
  endtask

  initial begin
    int sp;
    int st;
    int dc;
    dump.dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'h0;

    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();
    check_reset_outputs("idle");

    // Full dump with the sink always ready, plus first-word latency
    push_range(0, 31, 0);
    dc       = done_cnt;
    done_pos = -1;
    start    = 1'b1;
    sp       = pos;
    tick();
    start = 1'b0;
    check("lat_read_busy", busy, 1'b1);
    check("lat_read_valid", dump.dump_valid, 1'b0);
    tick();
    check("lat_hold_valid", dump.dump_valid, 1'b1);
    check("lat_hold_index", dump.dump_index, 5'd0);
    for (int c = 0; c < 200 && busy; c++) tick();
    check("full_done_count", done_cnt - dc, 1);
    check("full_done_cycle", done_pos - sp, 65);
    check("full_queue_empty", exp_q.size(), 0);
    check("full_busy_after", busy, 1'b0);

    // Backpressure on index 3
    push_range(0, 31, 0);
    dc = done_cnt;
    run_dump(3, -1, -1, -1, sp, st);
    check("bp_stalls", st, 5);
    check("bp_done_count", done_cnt - dc, 1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Abort while index 10 is held, then a clean restart
    push_range(0, 9, 0);
    dc = done_cnt;
    run_dump(-1, 10, -1, -1, sp, st);
    check("abort_valid", dump.dump_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick();
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_queue_empty", exp_q.size(), 0);
    push_range(0, 31, 0);
    dc       = done_cnt;
    done_pos = -1;
    run_dump(-1, -1, -1, -1, sp, st);
    check("restart_done_cycle", done_pos - sp, 65);
    check("restart_queue_empty", exp_q.size(), 0);

    // start while busy is ignored
    push_range(0, 31, 0);
    dc       = done_cnt;
    done_pos = -1;
    run_dump(-1, -1, 12, -1, sp, st);
    check("busy_start_done_count", done_cnt - dc, 1);
    check("busy_start_done_cycle", done_pos - sp, 65);
    check("busy_start_queue_empty", exp_q.size(), 0);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    tick();
    check("start_abort_busy2", busy, 1'b0);
    check("start_abort_valid", dump.dump_valid, 1'b0);

    // Register write during the dump shows up at its later read
    push_range(0, 31, 1);
    run_dump(-1, -1, -1, 5, sp, st);
    check("write_queue_empty", exp_q.size(), 0);
    regs[7] = 32'h1000_0007;

    // Asynchronous reset while index 20 is held
    push_range(0, 19, 0);
    dc    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && !(dump.dump_valid && dump.dump_index == 5'd20); c++) tick();
    check("rst_reached_20", dump.dump_index, 5'd20);
    dump.dump_ready = 1'b0;
    #1 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    tick();
    tick();
    reset           = 1'b1;
    dump.dump_ready = 1'b1;
    repeat (4) tick();
    check_reset_outputs("post_rst");
    check("post_rst_no_done", done_cnt - dc, 0);
    check("post_rst_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
